// File: rtl/alu16_mul_seq.sv
// -----------------------------------------------------------------------------
// alu16_mul_seq
//   Sequential unsigned WIDTH x WIDTH -> 2*WIDTH shift-add multiplier
//   controller. It sits one stage upstream of an external 74LS181-style
//   alu_16bit. The external ALU performs the per-cycle add (or pass-through),
//   and this block shifts the result into a 2*WIDTH accumulator over WIDTH
//   cycles. Data is active-high. The ALU carry-in and carry-out are active-low.
//
// Ports
//   clk         in   rising-edge clock
//   rst_n       in   asynchronous active-low reset
//   start       in   operation request, sampled only in IDLE
//   op_a        in   multiplicand, latched when start is accepted
//   op_b        in   multiplier, latched when start is accepted
//   busy        out  high in RUN and DONE
//   done        out  one-cycle pulse in DONE
//   product     out  result register, held until the next completion
//   alu_a       out  ALU a operand (accumulator high half)
//   alu_b       out  ALU b operand (latched multiplicand)
//   alu_select  out  ALU function select
//   alu_mode    out  ALU mode (0 arithmetic, 1 logic)
//   alu_cin     out  ALU carry-in (active-low, tied to "no carry")
//   alu_f       in   ALU result
//   alu_cout    in   ALU carry-out (active-low)
// -----------------------------------------------------------------------------
module alu16_mul_seq #(
  parameter int          WIDTH     = 16,
  parameter logic [3:0]  SEL_ADD   = 4'b1001,
  parameter logic [3:0]  SEL_PASSA = 4'b1111
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic [WIDTH-1:0]     op_a,
  input  logic [WIDTH-1:0]     op_b,
  output logic                 busy,
  output logic                 done,
  output logic [2*WIDTH-1:0]   product,
  output logic [WIDTH-1:0]     alu_a,
  output logic [WIDTH-1:0]     alu_b,
  output logic [3:0]           alu_select,
  output logic                 alu_mode,
  output logic                 alu_cin,
  input  logic [WIDTH-1:0]     alu_f,
  input  logic                 alu_cout
);

  localparam int                CW   = $clog2(WIDTH);
  localparam logic [CW-1:0]     LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    RUN  = 2'b01,
    DONE = 2'b10
  } state_t;

  state_t                state_q;
  logic                  busy_q;
  logic                  done_q;
  logic [CW-1:0]         count_q;
  logic [WIDTH-1:0]      mcand_q;
  logic [2*WIDTH-1:0]    acc_q;
  logic [2*WIDTH-1:0]    acc_d;
  logic [2*WIDTH-1:0]    product_q;
  logic                  add_cycle;
  logic                  carry_in_shift;

  // An add is requested only while running and the current multiplier bit
  // (acc low bit) is set. In every other cycle the ALU passes A through, so
  // the shift below still moves the accumulator correctly.
  assign add_cycle = (state_q == RUN) && acc_q[0];

  // ALU drive is purely combinational from state and registers.
  assign alu_a      = acc_q[2*WIDTH-1:WIDTH];
  assign alu_b      = mcand_q;
  assign alu_cin    = 1'b1;
  assign alu_select = add_cycle ? SEL_ADD : SEL_PASSA;
  assign alu_mode   = add_cycle ? 1'b0 : 1'b1;

  // The carry-out is active-low, so invert it. In pass-through cycles the
  // ALU carry output is meaningless, so a zero is shifted in instead.
  assign carry_in_shift = acc_q[0] ? ~alu_cout : 1'b0;

  // Shift the (2*WIDTH+1)-bit value {carry, f, acc_lo} right by one. The
  // bit that falls off is the multiplier bit consumed this cycle.
  always_comb begin
    acc_d = {carry_in_shift, alu_f, acc_q[WIDTH-1:1]};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      count_q   <= '0;
      mcand_q   <= '0;
      acc_q     <= '0;
      product_q <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          done_q <= 1'b0;
          if (start) begin
            mcand_q <= op_a;
            acc_q   <= {{WIDTH{1'b0}}, op_b};
            count_q <= '0;
            busy_q  <= 1'b1;
            state_q <= RUN;
          end
        end
        RUN: begin
          acc_q   <= acc_d;
          count_q <= count_q + 1'b1;
          // Fixed WIDTH iterations. There is deliberately no early exit on a
          // zero multiplier, so the latency never depends on the operands.
          if (count_q == LAST) begin
            product_q <= acc_d;
            done_q    <= 1'b1;
            state_q   <= DONE;
          end
        end
        DONE: begin
          // This always passes through IDLE, so start cannot chain directly.
          done_q  <= 1'b0;
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
        default: begin
          done_q  <= 1'b0;
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign busy    = busy_q;
  assign done    = done_q;
  assign product = product_q;

endmodule

// File: tb/tb_alu16_mul_seq.sv
module tb_alu16_mul_seq;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic [15:0] op_a;
  logic [15:0] op_b;
  logic        busy;
  logic        done;
  logic [31:0] product;
  logic [15:0] alu_a;
  logic [15:0] alu_b;
  logic [3:0]  alu_select;
  logic        alu_mode;
  logic        alu_cin;
  logic [15:0] alu_f;
  logic        alu_cout;

  int checks   = 0;
  int failures = 0;
  logic [31:0] prev_prod;

  alu16_mul_seq dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .op_a       (op_a),
    .op_b       (op_b),
    .busy       (busy),
    .done       (done),
    .product    (product),
    .alu_a      (alu_a),
    .alu_b      (alu_b),
    .alu_select (alu_select),
    .alu_mode   (alu_mode),
    .alu_cin    (alu_cin),
    .alu_f      (alu_f),
    .alu_cout   (alu_cout)
  );

  // Behavioural alu_16bit: A plus B (arithmetic mode) and F = A (logic mode).
  // The carries are active-low.
  logic [16:0] alu_sum;
  always_comb begin
    alu_sum = {1'b0, alu_a} + {1'b0, alu_b} + {16'h0, ~alu_cin};
    if (!alu_mode && alu_select == 4'b1001) begin
      alu_f    = alu_sum[15:0];
      alu_cout = ~alu_sum[16];
    end else if (alu_mode && alu_select == 4'b1111) begin
      alu_f    = alu_a;
      alu_cout = 1'b1;
    end else begin
      alu_f    = 16'h0000;
      alu_cout = 1'b1;
    end
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not end, got timeout required finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // One full operation. The expected select pattern is derived directly from
  // the multiplier: RUN cycle k adds exactly when bit k of op_b is set.
  task automatic do_op(input logic [15:0] a, input logic [15:0] b,
                       input bit pulse5, input string tag);
    logic [15:0] obs_add;
    logic        early_done;
    logic        busy_low;
    logic        aux_bad;
    logic [31:0] exp_prod;
    exp_prod   = 32'(a) * 32'(b);
    obs_add    = '0;
    early_done = 1'b0;
    busy_low   = 1'b0;
    aux_bad    = 1'b0;
    @(negedge clk);
    op_a  = a;
    op_b  = b;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    op_a  = $urandom;
    op_b  = $urandom;
    for (int k = 0; k < 16; k++) begin
      obs_add[k] = (alu_select == 4'b1001) && (alu_mode == 1'b0);
      if (done) early_done = 1'b1;
      if (!busy) busy_low = 1'b1;
      if (alu_cin !== 1'b1 || alu_b !== a) aux_bad = 1'b1;
      if (k == 5) begin
        check({tag, "_prod_held"}, product, prev_prod);
        if (pulse5) begin
          op_a  = 16'd3;
          op_b  = 16'd3;
          start = 1'b1;
        end
      end
      @(posedge clk); #1;
      start = 1'b0;
    end
    check({tag, "_sel_pattern"}, 32'(obs_add), 32'(b));
    check({tag, "_early_done"}, 32'(early_done), 32'd0);
    check({tag, "_busy_run"}, 32'(busy_low), 32'd0);
    check({tag, "_alu_aux"}, 32'(aux_bad), 32'd0);
    check({tag, "_done"}, 32'(done), 32'd1);
    check({tag, "_busy_done"}, 32'(busy), 32'd1);
    check({tag, "_product"}, product, exp_prod);
    prev_prod = exp_prod;
    @(posedge clk); #1;
    check({tag, "_idle_done"}, 32'(done), 32'd0);
    check({tag, "_idle_busy"}, 32'(busy), 32'd0);
    @(posedge clk); #1;
    check({tag, "_no_queue"}, 32'(busy), 32'd0);
    check({tag, "_prod_keep"}, product, exp_prod);
  endtask

  initial begin
    int          d_idx [$];
    logic [31:0] d_prod [$];
    rst_n     = 1'b0;
    start     = 1'b0;
    op_a      = '0;
    op_b      = '0;
    prev_prod = '0;

    // Reset state
    #12;
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_product", product, 32'd0);
    check("rst_select", 32'(alu_select), 32'h0000000F);
    check("rst_mode", 32'(alu_mode), 32'd1);
    check("rst_cin", 32'(alu_cin), 32'd1);
    @(negedge clk);
    rst_n = 1'b1;

    // Directed cases
    do_op(16'd12, 16'd2, 1'b0, "basic");
    do_op(16'hFFFF, 16'hFFFF, 1'b0, "carry");
    do_op(16'd0, 16'hABCD, 1'b0, "zero");
    do_op(16'd128, 16'd64, 1'b0, "p128x64");
    do_op(16'h8000, 16'd2, 1'b0, "msb");
    do_op(16'd1000, 16'd777, 1'b1, "handshake");

    // Randomized operations
    for (int r = 0; r < 24; r++) begin
      logic [15:0] ra, rb;
      ra = 16'($urandom);
      rb = 16'($urandom);
      case (r % 6)
        0: rb = 16'hFFFF;
        1: ra = 16'hFFFF;
        2: rb = 16'h0000;
        default: ;
      endcase
      do_op(ra, rb, r[0], "rand");
    end

    // Back-to-back with start held high
    @(negedge clk);
    op_a  = 16'd7;
    op_b  = 16'd9;
    start = 1'b1;
    @(posedge clk); #1;
    op_a = 16'd5;
    op_b = 16'd5;
    for (int i = 1; i <= 40; i++) begin
      @(posedge clk); #1;
      if (done) begin
        d_idx.push_back(i);
        d_prod.push_back(product);
      end
      if (i == 18) start = 1'b0;
    end
    check("b2b_count", 32'(d_idx.size()), 32'd2);
    if (d_idx.size() == 2) begin
      check("b2b_first_edge", 32'(d_idx[0]), 32'd16);
      check("b2b_spacing", 32'(d_idx[1] - d_idx[0]), 32'd18);
      check("b2b_prod0", d_prod[0], 32'd63);
      check("b2b_prod1", d_prod[1], 32'd25);
    end
    prev_prod = 32'd25;
    repeat (3) @(posedge clk);

    // Asynchronous reset in the middle of RUN
    @(negedge clk);
    op_a  = 16'h1234;
    op_b  = 16'h5678;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (8) @(posedge clk);
    #2;
    check("mid_busy_before", 32'(busy), 32'd1);
    rst_n = 1'b0;
    #1;
    check("mid_rst_busy", 32'(busy), 32'd0);
    check("mid_rst_done", 32'(done), 32'd0);
    check("mid_rst_product", product, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    prev_prod = '0;
    do_op(16'd100, 16'd200, 1'b0, "after_rst");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
